fp_accumulator: RTL and testbench
=================================

FP_ACCUMULATOR -- requirements
Module: fp_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the beat counter.
REQ-002 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous active-low reset; it is the only reset.
REQ-004 SHALL have port clr, input, 1: synchronous abort of the current accumulation.
REQ-005 SHALL have port in_valid, input, 1: input beat valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts a beat.
REQ-007 SHALL have port in_data, input, 32: IEEE-754 single-precision operand.
REQ-008 SHALL have port in_sub, input, 1: 1 = subtract in_data from the accumulator, 0 = add.
REQ-009 SHALL have port in_last, input, 1: marks the final beat of a group.
REQ-010 SHALL have port out_valid, output, 1: result valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port out_data, output, 32: accumulated single-precision sum.
REQ-013 SHALL have port out_count, output, CNT_W: number of beats accepted in the group.
REQ-014 SHALL have port out_sat, output, 1: beat counter saturated in this group.

Function
REQ-015 SHALL implement FSM states ACC and HOLD; in_ready = (state==ACC), out_valid = (state==HOLD).
REQ-016 SHALL accept a beat when in_valid && in_ready; accumulator, counter and state update on that clock edge.
REQ-017 SHALL load the first beat of a group directly into the accumulator as in_data, with bit 31 inverted when in_sub=1; the adder is not used for this beat.
REQ-018 SHALL update acc <= floating_unit(A=acc, B=in_data, A_S=in_sub).result on every later accepted beat, sustaining one beat per cycle.
REQ-019 SHALL increment the counter on each accepted beat, saturating at 2^CNT_W-1 and setting sticky out_sat on the beat that would overflow.
REQ-020 SHALL move ACC->HOLD on the accepted beat with in_last=1; out_data/out_count/out_sat then show the result including that beat, in the next cycle.
REQ-021 SHALL hold out_data, out_count and out_sat stable throughout HOLD while out_ready=0.
REQ-022 SHALL, on the HOLD edge with out_ready=1, return to ACC and clear the accumulator, counter, out_sat and the first-beat flag; the next beat is accepted no earlier than the following cycle.
REQ-023 SHALL, when clr=1 in either state, discard the group (accumulator 0x00000000, count 0, out_sat 0, state ACC); clr takes priority over a simultaneous accepted beat or out handshake.
REQ-024 SHALL pass NaN/Inf results from floating_unit through unmodified; no exception flags.
REQ-025 SHALL keep out_data = accumulator register at all times; no combinational path from in_data to out_data.

Reset
REQ-026 SHALL, on rising clk with rst_n=0: state ACC, accumulator 0x00000000, counter 0, out_sat 0, first-beat flag set, out_valid 0, in_ready 1.
REQ-027 SHALL apply reset in the middle of a group or in HOLD with the same result; a pending result is lost.

Structure
REQ-028 SHALL place the state enum (ACC, HOLD), the FP_ZERO constant 32'h00000000, and the sign-bit index constant in shared package fp_acc_pkg.
REQ-029 SHALL instantiate the existing floating_unit exactly once as its only sub-module; all sequential logic stays in fp_accumulator.

Verification
REQ-030 SHALL check: beats 0x3F800000 (1.0), 0x40000000 (2.0, last), in_sub=0 -> out_data 0x40400000 (3.0), out_count 2.
REQ-031 SHALL check: 0x40400000 (3.0), then 0x3F800000 (1.0, in_sub=1, last) -> out_data 0x40000000 (2.0), count 2.
REQ-032 SHALL check: single beat 0x3F800000 with in_sub=1, last -> out_data 0xBF800000, count 1.
REQ-033 SHALL check: out_ready held low 3 cycles in HOLD -> out_data stable and in_ready=0; handshake on the 4th cycle -> in_ready=1 on the next cycle.
REQ-034 SHALL check: rst_n=0 for one cycle after 2 of 3 beats -> out_valid=0, in_ready=1; a new group 0x3FC00000 (1.5, last) -> out_data 0x3FC00000, count 1.
REQ-035 SHALL check: CNT_W=2, 5 beats of 0x3F000000 (0.5, last on the 5th) -> out_data 0x40200000 (2.5), out_count 3, out_sat 1; clr with a simultaneous beat -> beat dropped.

Source files
------------

// File: rtl/fp_acc_pkg.sv
// Shared definitions for the floating-point accumulator: FSM state type,
// the all-zero accumulator value and the IEEE-754 sign-bit position.
package fp_acc_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_e;

  localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
  localparam int          SIGN_BIT = 31;

endpackage

// File: rtl/fp_accumulator_floating_unit.sv
// Combinational IEEE-754 single-precision adder/subtractor.
// result = A + B when A_S = 0, A - B when A_S = 1.
// Rounding is round-to-nearest-even. Subnormal operands and results are
// supported. NaN operands and (+Inf) + (-Inf) produce a quiet NaN.
module floating_unit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        A_S,
  output logic [31:0] result
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        sign_a, sign_b, big_s;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [7:0]  big_e, small_e, diff;
  logic [26:0] big_m, small_m, aligned, norm;
  logic        sticky, round_up;
  logic [27:0] sum;
  logic [9:0]  exp_n;
  logic [24:0] mant;

  // Align, add/subtract, normalise and round the two operands.
  always_comb begin
    sign_a  = A[31];
    sign_b  = B[31] ^ A_S;
    a_nan   = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
    b_nan   = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
    a_inf   = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
    b_inf   = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
    sticky  = 1'b0;
    aligned = 27'd0;

    if (A[30:0] >= B[30:0]) begin
      big_s   = sign_a;
      big_e   = (A[30:23] == 8'd0) ? 8'd1 : A[30:23];
      small_e = (B[30:23] == 8'd0) ? 8'd1 : B[30:23];
      big_m   = {(A[30:23] != 8'd0), A[22:0], 3'b000};
      small_m = {(B[30:23] != 8'd0), B[22:0], 3'b000};
    end else begin
      big_s   = sign_b;
      big_e   = (B[30:23] == 8'd0) ? 8'd1 : B[30:23];
      small_e = (A[30:23] == 8'd0) ? 8'd1 : A[30:23];
      big_m   = {(B[30:23] != 8'd0), B[22:0], 3'b000};
      small_m = {(A[30:23] != 8'd0), A[22:0], 3'b000};
    end

    diff = big_e - small_e;
    if (diff > 8'd26) begin
      aligned = {26'd0, |small_m};
    end else begin
      aligned    = small_m >> diff;
      sticky     = |(small_m & ((27'd1 << diff) - 27'd1));
      aligned[0] = aligned[0] | sticky;
    end

    if (big_s == (sign_a ^ sign_b ^ big_s))
      sum = {1'b0, big_m} + {1'b0, aligned};
    else
      sum = {1'b0, big_m} - {1'b0, aligned};

    exp_n = {2'b00, big_e};
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = exp_n + 10'd1;
    end else begin
      norm = sum[26:0];
      for (int i = 0; i < 26; i++) begin
        if (!norm[26] && (exp_n > 10'd1)) begin
          norm  = norm << 1;
          exp_n = exp_n - 10'd1;
        end
      end
    end

    round_up = norm[2] && (norm[1] || norm[0] || norm[3]);
    mant     = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (mant[24]) begin
      mant  = mant >> 1;
      exp_n = exp_n + 10'd1;
    end

    if (sum == 28'd0)
      result = {sign_a & sign_b, 31'd0};
    else if (exp_n >= 10'd255)
      result = {big_s, 8'hFF, 23'd0};
    else
      result = {big_s, (mant[23] ? exp_n[7:0] : 8'd0), mant[22:0]};

    if (a_nan || b_nan || (a_inf && b_inf && (sign_a != sign_b)))
      result = QNAN;
    else if (a_inf)
      result = A;
    else if (b_inf)
      result = {sign_b, B[30:0]};
  end

endmodule

// File: rtl/fp_accumulator.sv
// Streaming single-precision accumulator. Beats are summed (or subtracted)
// into a register until a beat marked last arrives; the result is then held
// until the consumer takes it, after which a fresh group starts.
module fp_accumulator
  import fp_acc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  acc_state_e       state_q;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             first_q;
  logic [31:0]      fu_result;
  logic             cnt_full;

  floating_unit u_fu (
    .A      (acc_q),
    .B      (in_data),
    .A_S    (in_sub),
    .result (fu_result)
  );

  // Next accumulator/counter values for an accepted beat; the first beat of
  // a group bypasses the adder so a lone beat is never disturbed by rounding.
  always_comb begin
    cnt_full = (cnt_q == {CNT_W{1'b1}});
    acc_d    = first_q ? {in_data[SIGN_BIT] ^ in_sub, in_data[SIGN_BIT-1:0]}
                       : fu_result;
    cnt_d    = cnt_full ? cnt_q : cnt_q + 1'b1;
    sat_d    = sat_q | cnt_full;
  end

  // Group FSM: accumulate in ACC, present the result in HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q <= ACC;
      acc_q   <= FP_ZERO;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      case (state_q)
        ACC: begin
          if (in_valid) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            first_q <= 1'b0;
            if (in_last) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= ACC;
            acc_q   <= FP_ZERO;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            first_q <= 1'b1;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed testbench for fp_accumulator. Two instances share stimulus: the
// default-width one and a 2-bit counter one used for saturation.
module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_sub, in_last, out_ready;
  logic [31:0] in_data;

  logic        in_ready, out_valid, out_sat;
  logic [31:0] out_data;
  logic [7:0]  out_count;

  logic        in_ready2, out_valid2, out_sat2;
  logic [31:0] out_data2;
  logic [1:0]  out_count2;

  int checkCount = 0;
  int failCount  = 0;

  fp_accumulator #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_sat(out_sat)
  );

  fp_accumulator #(.CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_count(out_count2), .out_sat(out_sat2)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present one beat at a negedge and hold it until it is accepted.
  task automatic applyStimulus(input logic [31:0] data, input logic sub,
                               input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_sub   = sub;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) checkOutput("beatTimeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_sub   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitResult();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resultValid", 32'(out_valid), 32'd1);
  endtask

  task automatic takeResult();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_sub = 1'b0;
    in_last = 1'b0; out_ready = 1'b0; in_data = 32'h0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstInReady",  32'(in_ready),  32'd1);
    checkOutput("rstData",     out_data,       32'h0000_0000);
    checkOutput("rstCount",    32'(out_count), 32'd0);
    checkOutput("rstSat",      32'(out_sat),   32'd0);
    rst_n = 1'b1;

    // 1.0 + 2.0 = 3.0
    applyStimulus(32'h3F80_0000, 1'b0, 1'b0);
    applyStimulus(32'h4000_0000, 1'b0, 1'b1);
    waitResult();
    checkOutput("addData",    out_data,       32'h4040_0000);
    checkOutput("addCount",   32'(out_count), 32'd2);
    checkOutput("addInReady", 32'(in_ready),  32'd0);
    takeResult();
    checkOutput("addClrReady", 32'(in_ready),  32'd1);
    checkOutput("addClrData",  out_data,       32'h0000_0000);
    checkOutput("addClrCount", 32'(out_count), 32'd0);

    // 3.0 - 1.0 = 2.0
    applyStimulus(32'h4040_0000, 1'b0, 1'b0);
    applyStimulus(32'h3F80_0000, 1'b1, 1'b1);
    waitResult();
    checkOutput("subData",  out_data,       32'h4000_0000);
    checkOutput("subCount", 32'(out_count), 32'd2);
    takeResult();

    // single negated beat, then HOLD with out_ready low for 3 cycles
    applyStimulus(32'h3F80_0000, 1'b1, 1'b1);
    waitResult();
    checkOutput("negData",  out_data,       32'hBF80_0000);
    checkOutput("negCount", 32'(out_count), 32'd1);
    in_valid = 1'b1;
    in_data  = 32'h4000_0000;
    for (int k = 0; k < 3; k++) begin
      checkOutput("holdData",    out_data,       32'hBF80_0000);
      checkOutput("holdInReady", 32'(in_ready),  32'd0);
      checkOutput("holdCount",   32'(out_count), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    takeResult();
    checkOutput("hsInReady",  32'(in_ready),  32'd1);
    checkOutput("hsOutValid", 32'(out_valid), 32'd0);

    // reset in the middle of a group
    applyStimulus(32'h3F80_0000, 1'b0, 1'b0);
    applyStimulus(32'h4000_0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midRstValid", 32'(out_valid), 32'd0);
    checkOutput("midRstReady", 32'(in_ready),  32'd1);
    checkOutput("midRstData",  out_data,       32'h0000_0000);
    applyStimulus(32'h3FC0_0000, 1'b0, 1'b1);
    waitResult();
    checkOutput("postRstData",  out_data,       32'h3FC0_0000);
    checkOutput("postRstCount", 32'(out_count), 32'd1);
    takeResult();

    // five beats of 0.5: narrow counter saturates at 3
    for (int k = 0; k < 5; k++)
      applyStimulus(32'h3F00_0000, 1'b0, (k == 4));
    waitResult();
    checkOutput("satData",     out_data2,       32'h4020_0000);
    checkOutput("satCount",    32'(out_count2), 32'd3);
    checkOutput("satFlag",     32'(out_sat2),   32'd1);
    checkOutput("wideData",    out_data,        32'h4020_0000);
    checkOutput("wideCount",   32'(out_count),  32'd5);
    checkOutput("wideSatFlag", 32'(out_sat),    32'd0);
    takeResult();
    checkOutput("satCleared", 32'(out_sat2), 32'd0);

    // clr together with an accepted beat drops the beat
    applyStimulus(32'h3F80_0000, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h4000_0000;
    clr      = 1'b1;
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    checkOutput("clrData",  out_data,       32'h0000_0000);
    checkOutput("clrCount", 32'(out_count), 32'd0);
    checkOutput("clrReady", 32'(in_ready),  32'd1);
    applyStimulus(32'h3F00_0000, 1'b0, 1'b1);
    waitResult();
    checkOutput("afterClrData",  out_data,       32'h3F00_0000);
    checkOutput("afterClrCount", 32'(out_count), 32'd1);

    // clr while holding a result discards it
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clrHoldValid", 32'(out_valid), 32'd0);
    checkOutput("clrHoldData",  out_data,       32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule
